// File: rtl/ps2_key_sequencer_if.sv
// Key event handshake between the sequencer and the CPU/MMIO consumer.
// master: producer drives event fields and valid, consumer drives ready.
interface ps2_key_sequencer_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_ascii;
    logic [7:0] ev_code;
    logic [2:0] ev_flags;

    modport master (
        output ev_valid,
        output ev_ascii,
        output ev_code,
        output ev_flags,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_ascii,
        input  ev_code,
        input  ev_flags,
        output ev_ready
    );
endinterface

// File: rtl/ps2_key_sequencer.sv
// PS/2 scancode sequencer: E0/F0 prefix decode, LUT drive, held-key and
// typematic tracking, and an event FIFO toward the CPU.
// Ports:
//   clk, clrn           : clock, async active-low reset
//   code_valid, code    : raw scancode byte strobe from the PS/2 receiver
//   lut_key, lut_ascii  : final scancode to the lookup table and its result
//   ev                  : event FIFO head {ascii, code, flags} with valid/ready
//   held, held_code     : currently held key
//   press_count         : count of new (non-repeat) presses
//   overflow, clr_ovf   : sticky drop flag and its synchronous clear
module ps2_key_sequencer #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 clrn,
    input  logic                 code_valid,
    input  logic [7:0]           code,
    output logic [7:0]           lut_key,
    input  logic [7:0]           lut_ascii,
    ps2_key_sequencer_if.master  ev,
    output logic                 held,
    output logic [7:0]           held_code,
    output logic [CNT_W-1:0]     press_count,
    output logic                 overflow,
    input  logic                 clr_ovf
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];
    localparam logic [AW:0] ONE_C = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PONE_C = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        P_E0,
        P_F0,
        P_E0F0
    } state_t;

    state_t state;
    state_t state_n;

    logic is_e0;
    logic is_f0;
    logic fin;
    logic fin_ext;
    logic fin_rel;

    assign is_e0 = (code == 8'hE0);
    assign is_f0 = (code == 8'hF0);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= IDLE;
        else       state <= state_n;
    end

    // Prefixes arriving after F0 carry no meaning and are dropped.
    always_comb begin
        state_n = state;
        fin     = 1'b0;
        fin_ext = 1'b0;
        fin_rel = 1'b0;
        if (code_valid) begin
            unique case (state)
                IDLE: begin
                    if (is_f0)      state_n = P_F0;
                    else if (is_e0) state_n = P_E0;
                    else            fin = 1'b1;
                end
                P_E0: begin
                    if (is_f0) begin
                        state_n = P_E0F0;
                    end else if (!is_e0) begin
                        fin     = 1'b1;
                        fin_ext = 1'b1;
                        state_n = IDLE;
                    end
                end
                P_F0: begin
                    if (!is_e0 && !is_f0) begin
                        fin     = 1'b1;
                        fin_rel = 1'b1;
                        state_n = IDLE;
                    end
                end
                P_E0F0: begin
                    if (!is_e0 && !is_f0) begin
                        fin     = 1'b1;
                        fin_ext = 1'b1;
                        fin_rel = 1'b1;
                        state_n = IDLE;
                    end
                end
            endcase
        end
    end

    // Stage: lut_key feeds the table during the following cycle, when
    // the stage samples lut_ascii and pushes.
    logic       stg_valid;
    logic [7:0] stg_code;
    logic       stg_ext;
    logic       stg_rel;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            lut_key   <= 8'h00;
            stg_valid <= 1'b0;
            stg_code  <= 8'h00;
            stg_ext   <= 1'b0;
            stg_rel   <= 1'b0;
        end else begin
            stg_valid <= fin;
            if (fin) begin
                lut_key  <= code;
                stg_code <= code;
                stg_ext  <= fin_ext;
                stg_rel  <= fin_rel;
            end
        end
    end

    // Held-key tracking; extended and plain keys with the same code differ.
    logic held_ext;
    logic match;
    logic rep;

    assign match = held && (held_code == stg_code) && (held_ext == stg_ext);
    assign rep   = !stg_rel && match;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            held        <= 1'b0;
            held_code   <= 8'h00;
            held_ext    <= 1'b0;
            press_count <= '0;
        end else if (stg_valid) begin
            if (stg_rel) begin
                if (match) held <= 1'b0;
            end else if (!rep) begin
                held        <= 1'b1;
                held_code   <= stg_code;
                held_ext    <= stg_ext;
                press_count <= press_count + CONE_C;
            end
        end
    end

    // Event FIFO, entry = {ext, rel, rep, code, ascii}.
    logic [18:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;
    logic [7:0]    stg_ascii;
    logic [18:0]   entry;
    logic [18:0]   head;

    assign full  = (count == DEPTH_C);
    assign pop   = ev.ev_valid && ev.ev_ready;
    assign push  = stg_valid && (!full || pop);
    assign drop  = stg_valid && full && !pop;

    assign stg_ascii = stg_ext ? 8'h00 : lut_ascii;
    assign entry = {stg_ext, stg_rel, rep, stg_code, stg_ascii};

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= entry;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PONE_C;
            if (pop)  rd_ptr <= rd_ptr + PONE_C;
            unique case ({push, pop})
                2'b10:   count <= count + ONE_C;
                2'b01:   count <= count - ONE_C;
                default: count <= count;
            endcase
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)        overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
        else if (clr_ovf) overflow <= 1'b0;
    end

    // Head fields read zero while empty so stale entries never leak.
    assign ev.ev_valid = (count != '0);
    assign head        = ev.ev_valid ? mem[rd_ptr] : 19'd0;
    assign ev.ev_ascii = head[7:0];
    assign ev.ev_code  = head[15:8];
    assign ev.ev_flags = head[18:16];

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Bench for ps2_key_sequencer: directed test-plan steps plus random bytes,
// checked against an event-level reference model.
module tb_ps2_key_sequencer;

    localparam int D = 8;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       code_valid = 1'b0;
    logic [7:0] code = 8'h00;
    logic [7:0] lut_key;
    logic [7:0] lut_ascii;
    logic       held;
    logic [7:0] held_code;
    logic [7:0] press_count;
    logic       overflow;
    logic       clr_ovf = 1'b0;

    int n_tests = 0;
    int n_fail = 0;

    ps2_key_sequencer_if ev_bus ();

    ps2_key_sequencer #(.FIFO_DEPTH(D), .CNT_W(8)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .code_valid (code_valid),
        .code       (code),
        .lut_key    (lut_key),
        .lut_ascii  (lut_ascii),
        .ev         (ev_bus.master),
        .held       (held),
        .held_code  (held_code),
        .press_count(press_count),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lut_fn(input logic [7:0] k);
        case (k)
            8'h1C: return 8'h41;
            8'h15: return 8'h51;
            8'h1D: return 8'h57;
            8'h24: return 8'h45;
            8'h2D: return 8'h52;
            8'h2C: return 8'h54;
            8'h35: return 8'h59;
            8'h3C: return 8'h55;
            8'h43: return 8'h49;
            8'h44: return 8'h4F;
            default: return k ^ 8'h5A;
        endcase
    endfunction

    always_comb lut_ascii = lut_fn(lut_key);

    // Reference model: events are {ext, rel, rep, code, ascii}.
    logic [18:0] q[$];
    logic       m_held, m_hext;
    logic [7:0] m_hcode, m_pc, m_key;
    logic       m_ovf;
    logic       pre_ext, pre_rel;
    logic       pend_v, pend_ext, pend_rel;
    logic [7:0] pend_code;

    task automatic model_reset();
        q.delete();
        m_held = 0; m_hext = 0; m_hcode = 0;
        m_pc = 0; m_key = 0; m_ovf = 0;
        pre_ext = 0; pre_rel = 0;
        pend_v = 0; pend_ext = 0; pend_rel = 0; pend_code = 0;
    endtask

    task automatic model_edge(input logic v, input logic [7:0] b,
                              input logic r, input logic c);
        bit do_pop;
        bit same;
        bit rep;
        bit dropped;
        logic [7:0] asc;
        do_pop = r && (q.size() > 0);
        dropped = 0;
        if (pend_v) begin
            same = m_held && m_hcode == pend_code && m_hext == pend_ext;
            rep = !pend_rel && same;
            if (pend_rel) begin
                if (same) m_held = 0;
            end else if (!rep) begin
                m_held = 1; m_hcode = pend_code; m_hext = pend_ext;
                m_pc = m_pc + 8'd1;
            end
            asc = pend_ext ? 8'h00 : lut_fn(pend_code);
            if (q.size() < D || do_pop) begin
                if (do_pop) begin void'(q.pop_front()); do_pop = 0; end
                q.push_back({pend_ext, pend_rel, rep, pend_code, asc});
            end else begin
                dropped = 1;
            end
        end
        if (do_pop) void'(q.pop_front());
        if (dropped) m_ovf = 1;
        else if (c) m_ovf = 0;
        pend_v = 0;
        if (v) begin
            if (b == 8'hE0) begin
                if (!pre_rel) pre_ext = 1;
            end else if (b == 8'hF0) begin
                pre_rel = 1;
            end else begin
                pend_v = 1; pend_code = b;
                pend_ext = pre_ext; pend_rel = pre_rel;
                m_key = b;
                pre_ext = 0; pre_rel = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [18:0] h;
        h = (q.size() > 0) ? q[0] : 19'd0;
        chk("ev_valid", 32'(ev_bus.ev_valid), 32'(q.size() > 0));
        chk("ev_ascii", 32'(ev_bus.ev_ascii), 32'(h[7:0]));
        chk("ev_code", 32'(ev_bus.ev_code), 32'(h[15:8]));
        chk("ev_flags", 32'(ev_bus.ev_flags), 32'(h[18:16]));
        chk("held", 32'(held), 32'(m_held));
        chk("held_code", 32'(held_code), 32'(m_hcode));
        chk("press_count", 32'(press_count), 32'(m_pc));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("lut_key", 32'(lut_key), 32'(m_key));
    endtask

    task automatic step(input logic v, input logic [7:0] b,
                        input logic r, input logic c);
        code_valid = v;
        code = b;
        ev_bus.ev_ready = r;
        clr_ovf = c;
        @(posedge clk);
        model_edge(v, b, r, c);
        #1;
        check_all();
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step(0, 8'h00, r, 0);
    endtask

    task automatic do_reset();
        code_valid = 0;
        clr_ovf = 0;
        clrn = 0;
        #2;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        clrn = 1;
    endtask

    logic [7:0] pool [8] = '{8'h1C, 8'h15, 8'h1D, 8'h75,
                            8'hE0, 8'hF0, 8'hF0, 8'h6B};

    initial begin
        ev_bus.ev_ready = 1'b1;
        model_reset();
        #1;
        do_reset();

        // Single make with LUT lookup, event visible two cycles later.
        step(1, 8'h1C, 1, 0);
        chk("t1_c1_empty", 32'(ev_bus.ev_valid), 32'd0);
        step(0, 8'h00, 1, 0);
        chk("t1_valid", 32'(ev_bus.ev_valid), 32'd1);
        chk("t1_ascii", 32'(ev_bus.ev_ascii), 32'h41);
        chk("t1_pc", 32'(press_count), 32'd1);
        idle(2, 1);

        // Typematic repeats then release.
        do_reset();
        step(1, 8'h1C, 1, 0);
        step(1, 8'h1C, 1, 0);
        step(1, 8'h1C, 1, 0);
        step(1, 8'hF0, 1, 0);
        step(1, 8'h1C, 1, 0);
        idle(3, 1);
        chk("t2_pc", 32'(press_count), 32'd1);
        chk("t2_held", 32'(held), 32'd0);

        // Extended make and release.
        step(1, 8'hE0, 1, 0);
        step(1, 8'h75, 1, 0);
        step(0, 8'h00, 1, 0);
        chk("t3_flags_make", 32'(ev_bus.ev_flags), 32'b100);
        chk("t3_held", 32'(held), 32'd1);
        step(1, 8'hE0, 1, 0);
        step(1, 8'hF0, 1, 0);
        step(1, 8'h75, 1, 0);
        step(0, 8'h00, 1, 0);
        chk("t3_flags_rel", 32'(ev_bus.ev_flags), 32'b110);
        chk("t3_released", 32'(held), 32'd0);
        idle(2, 1);

        // Fill with ready low, one event dropped, then drain and clear.
        do_reset();
        step(1, 8'h15, 0, 0);
        step(1, 8'h1D, 0, 0);
        step(1, 8'h24, 0, 0);
        step(1, 8'h2D, 0, 0);
        step(1, 8'h2C, 0, 0);
        step(1, 8'h35, 0, 0);
        step(1, 8'h3C, 0, 0);
        step(1, 8'h43, 0, 0);
        step(1, 8'h44, 0, 0);
        idle(2, 0);
        chk("t4_ovf", 32'(overflow), 32'd1);
        chk("t4_pc", 32'(press_count), 32'd9);
        chk("t4_head", 32'(ev_bus.ev_ascii), 32'h51);
        idle(9, 1);
        chk("t4_drained", 32'(ev_bus.ev_valid), 32'd0);
        step(0, 8'h00, 1, 1);
        chk("t4_clr", 32'(overflow), 32'd0);

        // Reset in the middle of a release prefix.
        step(1, 8'hF0, 1, 0);
        do_reset();
        step(1, 8'h1C, 1, 0);
        step(0, 8'h00, 1, 0);
        chk("t5_flags", 32'(ev_bus.ev_flags), 32'b000);
        idle(2, 1);

        // Back-to-back bytes pop on consecutive cycles.
        do_reset();
        step(1, 8'h15, 1, 0);
        step(1, 8'h1D, 1, 0);
        chk("t6_a", 32'(ev_bus.ev_ascii), 32'h51);
        step(1, 8'h24, 1, 0);
        chk("t6_b", 32'(ev_bus.ev_ascii), 32'h57);
        step(0, 8'h00, 1, 0);
        chk("t6_c", 32'(ev_bus.ev_ascii), 32'h45);
        idle(2, 1);

        // Random byte stream, random backpressure and clears.
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 10) < 6, pool[$urandom % 8],
                 ($urandom % 3) != 0, ($urandom % 12) == 0);
        end
        idle(D + 2, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_key_sequencer.md
Name: ps2_key_sequencer

Overview:
- Sequences the PS/2 scancode-to-ASCII lookup table.
- Consumes raw scancode bytes from the PS/2 receiver and decodes E0/F0 prefix sequences with an FSM.
- Drives the lookup table's key input with final scancodes only, tracks the held key, suppresses typematic repeats from the press counter, and buffers decoded key events in a FIFO with a valid/ready handshake toward the CPU/MMIO side.

Parameters:
FIFO_DEPTH, 8, event FIFO entries; power of two, >= 2
CNT_W, 8, width of press_count

Ports:
clk  in  1  system clock
clrn  in  1  asynchronous active-low reset
code_valid  in  1  one-cycle strobe: code holds a received scancode byte
code  in  8  scancode byte from PS/2 receiver
lut_key  out  8  registered final scancode presented to lookup table
lut_ascii  in  8  combinational ASCII result for lut_key
ev_valid  out  1  FIFO non-empty
ev_ready  in  1  consumer accepts head event
ev_ascii  out  8  head event ASCII (0x00 for extended keys)
ev_code  out  8  head event scancode (without prefixes)
ev_flags  out  3  head event {ext, release, repeat}
held  out  1  a key is currently held
held_code  out  8  scancode of held key
press_count  out  CNT_W  count of new (non-repeat) presses, wraps modulo 2^CNT_W
overflow  out  1  sticky: an event was dropped because FIFO full
clr_ovf  in  1  synchronous clear of overflow

Behaviour:
- Reset (clrn low, async): FSM=IDLE; lut_key=0; stage valid=0; FIFO empty (ev_valid=0; ev_ascii, ev_code, ev_flags read 0); held=0; held_code=0; press_count=0; overflow=0.
- Reset applies immediately and is released synchronously.
- FSM states: IDLE, P_E0, P_F0, P_E0F0. Transitions occur only on code_valid.
  - IDLE: 0xF0 -> P_F0; 0xE0 -> P_E0; other -> final make (ext=0), -> IDLE.
  - P_E0: 0xF0 -> P_E0F0; 0xE0 -> stay; other -> final make (ext=1), -> IDLE.
  - P_F0: other -> final release (ext=0), -> IDLE.
  - P_E0F0: other -> final release (ext=1), -> IDLE.
  - In P_F0 and P_E0F0, 0xE0 and 0xF0 are ignored (state unchanged).
- Pipeline:
  - Edge ending cycle N (final byte): lut_key<=code; stage registers capture code, ext, release; stage valid=1.
  - Cycle N+1: stage samples lut_ascii (forced to 0x00 if ext) and pushes at the edge ending N+1.
  - ev_valid rises in cycle N+2 when FIFO was empty. No bypass.
  - Throughput: one final byte per cycle.
- Repeat/held rules, evaluated at stage push time:
  - Make with held=1, code==held_code and ext matching the held key's ext: repeat=1; press_count unchanged.
  - Any other make: repeat=0; held<=1; held_code<=code; press_count+1.
  - Release of held_code (ext matching): held<=0.
  - Release of any other key: held unchanged.
  - Releases always carry repeat=0.
- FIFO:
  - Pop when ev_valid && ev_ready.
  - Push when full and no pop in the same cycle: event dropped; overflow<=1; held and press_count still updated.
  - Push and pop in the same cycle while full: push accepted.
  - Pointers wrap modulo FIFO_DEPTH; order preserved.
- overflow: set has priority over clr_ovf in the same cycle.
- lut_key holds its last value between events.

Test Plan:
1. code_valid with 0x1C at cycle 0, ev_ready=1 -> ev_valid in cycle 2 with ev_ascii=0x41, ev_code=0x1C, ev_flags=000; press_count=1; held=1; held_code=0x1C.
2. 0x1C,0x1C,0x1C,0xF0,0x1C -> four events with ascii 0x41, flags 000,001,001,010; press_count=1; held=0 at end.
3. 0xE0,0x75 then 0xE0,0xF0,0x75 -> events ascii 0x00, code 0x75, flags 100 then 110; held toggles 1 then 0.
4. ev_ready=0, FIFO_DEPTH=8, nine distinct makes (0x15,0x1D,0x24,0x2D,0x2C,0x35,0x3C,0x43,0x44) -> 8 stored, overflow=1, press_count=9. Then ev_ready=1 -> Q,W,E,R,T,Y,U,I in order. Then clr_ovf -> overflow=0.
5. 0xF0, then clrn low for 1 cycle mid-sequence, then 0x1C -> single make event with flags 000 (not release); all outputs zero during reset.
6. Back-to-back code_valid on consecutive cycles with 0x15,0x1D,0x24, ev_ready=1 -> ev_ascii 0x51,0x57,0x45 on three consecutive pop cycles, first in cycle 2.
